// File: rtl/decode_queue.sv
// RV32I decode queue: decodes each accepted instruction and buffers the control
// bundle in a DEPTH-entry FIFO between fetch and issue, with flush and halt lock.

package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } aluop_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    aluop_t     alu_op;
    logic       reg_wr;
    logic       d_wen;
    logic       d_ren;
    logic       alu_src;
    logic       shift;
    logic       jp_sel;
    logic       halt;
    logic       illegal;
    logic [1:0] pc_src;
    logic [2:0] rd_sel;
  } ctrl_t;
endpackage

module decode_queue
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_instr,
  input  logic [XLEN-1:0]            in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output aluop_t                     out_aluOp,
  output logic                       out_regWr,
  output logic                       out_dWEN,
  output logic                       out_dREN,
  output logic                       out_aluSrc,
  output logic                       out_shift,
  output logic                       out_jpSel,
  output logic                       out_halt,
  output logic                       out_illegal,
  output logic [XLEN-1:0]            out_imm,
  output logic [1:0]                 out_pcSrc,
  output logic [2:0]                 out_rdSel,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct3 -> ALU op; alt (funct7[5]) picks SUB/SRA where the encoding allows it
  function automatic aluop_t alu_from_f3(input logic [2:0] f3, input logic alt);
    aluop_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  ctrl_t              dec;
  logic signed [31:0] imm32;
  logic [6:0]         opcode;
  logic [2:0]         f3;

  ctrl_t           ctrl_q [DEPTH];
  ctrl_t           ctrl_d [DEPTH];
  logic [XLEN-1:0] pc_mem_q  [DEPTH];
  logic [XLEN-1:0] pc_mem_d  [DEPTH];
  logic [XLEN-1:0] imm_mem_q [DEPTH];
  logic [XLEN-1:0] imm_mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            halt_lock_q, halt_lock_d;
  logic            push, pop;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];

  // Combinational RV32I decode of the word fetch is presenting
  always_comb begin
    dec     = '0;
    imm32   = '0;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    if (in_instr[31:0] == 32'hFFFF_FFFF) begin
      dec.halt = 1'b1;
    end else begin
      case (opcode)
        OP_R: begin
          dec.reg_wr = 1'b1;
          dec.alu_op = alu_from_f3(f3, in_instr[30]);
        end
        OP_I_ALU: begin
          dec.reg_wr  = 1'b1;
          dec.alu_src = 1'b1;
          if (f3 == 3'b001 || f3 == 3'b101) begin
            dec.shift  = 1'b1;
            dec.alu_op = alu_from_f3(f3, in_instr[30]);
            imm32      = {27'd0, in_instr[24:20]};
          end else begin
            dec.alu_op = alu_from_f3(f3, 1'b0);
            imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
          end
        end
        OP_LOAD: begin
          dec.d_ren   = 1'b1;
          dec.reg_wr  = 1'b1;
          dec.alu_src = 1'b1;
          dec.rd_sel  = 3'd1;
          imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OP_STORE: begin
          dec.d_wen   = 1'b1;
          dec.alu_src = 1'b1;
          imm32       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        OP_BRANCH: begin
          dec.pc_src = 2'd1;
          case (f3[2:1])
            2'b10:   dec.alu_op = ALU_SLT;
            2'b11:   dec.alu_op = ALU_SLTU;
            default: dec.alu_op = ALU_SUB;
          endcase
          imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
        end
        OP_JAL: begin
          dec.reg_wr = 1'b1;
          dec.pc_src = 2'd2;
          dec.rd_sel = 3'd2;
          imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
        end
        OP_JALR: begin
          dec.reg_wr  = 1'b1;
          dec.pc_src  = 2'd3;
          dec.jp_sel  = 1'b1;
          dec.rd_sel  = 3'd2;
          dec.alu_src = 1'b1;
          imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OP_LUI: begin
          dec.reg_wr = 1'b1;
          dec.rd_sel = 3'd3;
          imm32      = {in_instr[31:12], 12'd0};
        end
        OP_AUIPC: begin
          dec.reg_wr = 1'b1;
          dec.rd_sel = 3'd4;
          imm32      = {in_instr[31:12], 12'd0};
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  assign in_ready  = (count_q < CW'(DEPTH)) && !halt_lock_q;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state for pointers, occupancy, halt lock and entry storage; flush wins
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    halt_lock_d = halt_lock_q;
    ctrl_d      = ctrl_q;
    pc_mem_d    = pc_mem_q;
    imm_mem_d   = imm_mem_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      halt_lock_d = 1'b0;
    end else begin
      if (push) begin
        ctrl_d[wr_ptr_q]    = dec;
        pc_mem_d[wr_ptr_q]  = in_pc;
        imm_mem_d[wr_ptr_q] = XLEN'(imm32);
        wr_ptr_d            = wr_ptr_q + PW'(1);
        halt_lock_d         = halt_lock_q | dec.halt;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers; reset also clears storage so the head reads as zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      halt_lock_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i]    <= '0;
        pc_mem_q[i]  <= '0;
        imm_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      halt_lock_q <= halt_lock_d;
      ctrl_q      <= ctrl_d;
      pc_mem_q    <= pc_mem_d;
      imm_mem_q   <= imm_mem_d;
    end
  end

  assign count       = count_q;
  assign out_pc      = pc_mem_q[rd_ptr_q];
  assign out_imm     = imm_mem_q[rd_ptr_q];
  assign out_rs1     = ctrl_q[rd_ptr_q].rs1;
  assign out_rs2     = ctrl_q[rd_ptr_q].rs2;
  assign out_rd      = ctrl_q[rd_ptr_q].rd;
  assign out_aluOp   = ctrl_q[rd_ptr_q].alu_op;
  assign out_regWr   = ctrl_q[rd_ptr_q].reg_wr;
  assign out_dWEN    = ctrl_q[rd_ptr_q].d_wen;
  assign out_dREN    = ctrl_q[rd_ptr_q].d_ren;
  assign out_aluSrc  = ctrl_q[rd_ptr_q].alu_src;
  assign out_shift   = ctrl_q[rd_ptr_q].shift;
  assign out_jpSel   = ctrl_q[rd_ptr_q].jp_sel;
  assign out_halt    = ctrl_q[rd_ptr_q].halt;
  assign out_illegal = ctrl_q[rd_ptr_q].illegal;
  assign out_pcSrc   = ctrl_q[rd_ptr_q].pc_src;
  assign out_rdSel   = ctrl_q[rd_ptr_q].rd_sel;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: hand-decoded instruction vectors checked at
// the queue head, plus fill/wrap, halt lock, flush and reset scenarios.

module tb_decode_queue;
  import cpu_types_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  in_instr = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  aluop_t           out_aluOp;
  logic             out_regWr, out_dWEN, out_dREN, out_aluSrc, out_shift;
  logic             out_jpSel, out_halt, out_illegal;
  logic [XLEN-1:0]  out_imm;
  logic [1:0]       out_pcSrc;
  logic [2:0]       out_rdSel;
  logic [2:0]       count;

  int n_cmp = 0;
  int n_err = 0;

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_aluOp(out_aluOp),
    .out_regWr(out_regWr), .out_dWEN(out_dWEN), .out_dREN(out_dREN),
    .out_aluSrc(out_aluSrc), .out_shift(out_shift), .out_jpSel(out_jpSel),
    .out_halt(out_halt), .out_illegal(out_illegal), .out_imm(out_imm),
    .out_pcSrc(out_pcSrc), .out_rdSel(out_rdSel), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_zero_head(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_pc"}, out_pc, 32'd0);
    check({tag, "_imm"}, out_imm, 32'd0);
    check({tag, "_flags"},
          32'({out_rs1, out_rs2, out_rd, 4'(out_aluOp), out_regWr, out_dWEN, out_dREN,
               out_aluSrc, out_shift, out_jpSel, out_halt, out_illegal, out_pcSrc, out_rdSel}),
          32'd0);
  endtask

  initial begin
    // 1: reset, then addi x1,x0,5
    step();
    step();
    RST = 1'b0;
    check_zero_head("rst");
    out_ready = 1'b1;
    push(32'h0050_0093, 32'h0000_0100);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_rd", 32'(out_rd), 32'd1);
    check("addi_rs1", 32'(out_rs1), 32'd0);
    check("addi_imm", out_imm, 32'd5);
    check("addi_alu", 32'(out_aluOp), 32'(ALU_ADD));
    check("addi_regwr", 32'(out_regWr), 32'd1);
    check("addi_alusrc", 32'(out_aluSrc), 32'd1);
    check("addi_rdsel", 32'(out_rdSel), 32'd0);
    check("addi_count", 32'(count), 32'd1);
    check("addi_pc", out_pc, 32'h0000_0100);
    step();
    check("addi_drained", 32'(count), 32'd0);

    // 2: sw, then beq enqueued on the same edge sw is consumed
    push(32'h0020_A423, 32'h0000_0104);
    check("sw_dwen", 32'(out_dWEN), 32'd1);
    check("sw_regwr", 32'(out_regWr), 32'd0);
    check("sw_rs1", 32'(out_rs1), 32'd1);
    check("sw_rs2", 32'(out_rs2), 32'd2);
    check("sw_imm", out_imm, 32'd8);
    check("sw_alu", 32'(out_aluOp), 32'(ALU_ADD));
    push(32'hFE20_8EE3, 32'h0000_0108);
    check("beq_count", 32'(count), 32'd1);
    check("beq_pcsrc", 32'(out_pcSrc), 32'd1);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_alu", 32'(out_aluOp), 32'(ALU_SUB));
    step();
    push(32'h0040_A283, 32'h0000_010C);   // lw x5,4(x1)
    check("lw_dren", 32'(out_dREN), 32'd1);
    check("lw_rdsel", 32'(out_rdSel), 32'd1);
    check("lw_rd_imm", {out_rd, out_imm[26:0]}, {5'd5, 27'd4});
    step();
    push(32'h4040_D193, 32'h0000_0110);   // srai x3,x1,4
    check("srai_shift", 32'(out_shift), 32'd1);
    check("srai_alu", 32'(out_aluOp), 32'(ALU_SRA));
    check("srai_imm", out_imm, 32'd4);
    step();

    // 3: fill with consumer stalled, overflow attempt, then drain across wrap
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push((32'(k) << 20) | (32'(k) << 7) | 32'h13, 32'h200 + 32'(4 * (k - 1)));
    end
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    push(32'h0050_0293, 32'h0000_0210);
    check("full_ignore", 32'(count), 32'd4);
    check("full_head", 32'(out_rd), 32'd1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("full_deq_count", 32'(count), 32'd3);
    for (int k = 2; k <= 4; k++) begin
      check("wrap_order_rd", 32'(out_rd), 32'(k));
      check("wrap_order_pc", out_pc, 32'h200 + 32'(4 * (k - 1)));
      step();
    end
    check("wrap_empty", 32'(out_valid), 32'd0);

    // 4: halt lock
    out_ready = 1'b0;
    push(32'h0010_0093, 32'h0000_0300);
    push(32'hFFFF_FFFF, 32'h0000_0304);
    check("halt_ready", 32'(in_ready), 32'd0);
    push(32'h0020_0113, 32'h0000_0308);
    check("halt_block", 32'(count), 32'd2);
    out_ready = 1'b1;
    check("halt_first", 32'(out_halt), 32'd0);
    step();
    check("halt_entry", 32'(out_halt), 32'd1);
    check("halt_regwr", 32'(out_regWr), 32'd0);
    check("halt_illegal", 32'(out_illegal), 32'd0);
    step();
    check("halt_drained", 32'(count), 32'd0);
    check("halt_still_locked", 32'(in_ready), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("halt_flush_ready", 32'(in_ready), 32'd1);
    check("halt_flush_count", 32'(count), 32'd0);

    // 5: flush beats concurrent enqueue and dequeue
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) push(32'h0010_0093, 32'h400 + 32'(k));
    check("pre_flush_count", 32'(count), 32'd4);
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h0010_0093;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    step();
    check("flush_nothing", 32'(count), 32'd0);

    // 6: illegal opcode, then reset with entries pending
    out_ready = 1'b0;
    push(32'h0000_007F, 32'h0000_0500);
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_ctrl", 32'({out_regWr, out_dWEN, out_dREN}), 32'd0);
    check("ill_imm", out_imm, 32'd0);
    push(32'h0040_A283, 32'h0000_0504);
    push(32'h4040_D193, 32'h0000_0508);
    check("pre_rst_count", 32'(count), 32'd3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_zero_head("mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
